// File: rtl/grf_wb_arbiter.sv
// Shares the single GRF write port between the W stage and an in-order late-writeback
// queue; publishes pending-write mask, kills stale queued writes, flags head starvation.
module grf_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p_we,
  input  logic [4:0]             p_a3,
  input  logic [31:0]            p_wd,
  input  logic [31:0]            p_pc,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [4:0]             m_a3,
  input  logic [31:0]            m_wd,
  input  logic [31:0]            m_pc,
  output logic                   grf_we,
  output logic [4:0]             grf_a3,
  output logic [31:0]            grf_wd,
  output logic [31:0]            grf_pc,
  output logic [31:0]            pend_mask,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   starve
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_CNT = SW'(STARVE_MAX);

  logic          r_live [DEPTH];
  logic [4:0]    r_a3   [DEPTH];
  logic [31:0]   r_wd   [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;

  logic          w_pw;
  logic          w_full;
  logic          w_empty;
  logic          w_head_live;
  logic          w_push;
  logic          w_pop;
  logic          w_push_live;
  logic [CW-1:0] w_count_nxt;
  logic [SW-1:0] w_starve_nxt;
  logic [31:0]   w_mask;

  assign w_pw        = p_we && (p_a3 != 5'd0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == {CW{1'b0}});
  assign w_head_live = !w_empty && r_live[r_rptr];
  assign m_ready     = reset && !w_full;
  assign w_push      = m_valid && m_ready && (m_a3 != 5'd0);
  // A dead head is discarded even while the W stage owns the port.
  assign w_pop       = !w_empty && (!w_head_live || !w_pw);
  // The W-stage write in the same cycle is younger, so a matching push is born stale.
  assign w_push_live = !(w_pw && (m_a3 == p_a3));

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Starvation counter next-state: counts denied cycles of a live head, saturating.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = {SW{1'b0}};
    end else if (w_head_live && w_pw && (r_starve != STARVE_CNT)) begin
      w_starve_nxt = r_starve + SW'(1);
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // Queue storage, live bits and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_live[i] <= 1'b0;
        r_a3[i]   <= 5'd0;
        r_wd[i]   <= 32'd0;
        r_pc[i]   <= 32'd0;
      end
      r_wptr <= {AW{1'b0}};
      r_rptr <= {AW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pw && (r_a3[i] == p_a3)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_live[r_rptr] <= 1'b0;
        r_rptr         <= r_rptr + AW'(1);
      end
      if (w_push) begin
        r_live[r_wptr] <= w_push_live;
        r_a3[r_wptr]   <= m_a3;
        r_wd[r_wptr]   <= m_wd;
        r_pc[r_wptr]   <= m_pc;
        r_wptr         <= r_wptr + AW'(1);
      end
    end
  end

  // Occupancy and starvation state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= {CW{1'b0}};
      r_starve <= {SW{1'b0}};
    end else begin
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Port select: W stage first, then a live queue head.
  always_comb begin
    grf_we = 1'b0;
    grf_a3 = p_a3;
    grf_wd = p_wd;
    grf_pc = p_pc;
    if (!reset) begin
      grf_we = 1'b0;
    end else if (w_pw) begin
      grf_we = 1'b1;
    end else if (w_head_live) begin
      grf_we = 1'b1;
      grf_a3 = r_a3[r_rptr];
      grf_wd = r_wd[r_rptr];
      grf_pc = r_pc[r_rptr];
    end else begin
      grf_we = 1'b0;
    end
  end

  // Pending-write mask over live entries only.
  always_comb begin
    w_mask = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) begin
      w_mask = w_mask | (r_live[i] ? (32'h0000_0001 << r_a3[i]) : 32'h0000_0000);
    end
  end

  assign pend_mask  = w_mask & ~32'h0000_0001;
  assign fifo_count = r_count;
  assign starve     = (r_starve == STARVE_CNT);

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed self-checking bench for grf_wb_arbiter (DEPTH=4, STARVE_MAX=8).
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_we;
  logic [4:0]  p_a3;
  logic [31:0] p_wd;
  logic [31:0] p_pc;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic [31:0] m_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_count;
  logic        starve;

  int errors = 0;
  int checks = 0;
  int r9_writes = 0;
  logic [31:0] r9_last = 32'd0;
  int stale_writes = 0;

  grf_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .pend_mask(pend_mask), .fifo_count(fifo_count), .starve(starve)
  );

  always #5 clk = ~clk;

  // Observe writes that actually reach the register file.
  always @(posedge clk) begin
    if (grf_we && grf_a3 == 5'd9) begin
      r9_writes <= r9_writes + 1;
      r9_last   <= grf_wd;
    end
    if (grf_we && (grf_a3 == 5'd21 || grf_a3 == 5'd22 || grf_a3 == 5'd23)) begin
      stale_writes <= stale_writes + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p_we = 1'b0; p_a3 = 5'd0; p_wd = 32'd0; p_pc = 32'd0;
    m_valid = 1'b0; m_a3 = 5'd0; m_wd = 32'd0; m_pc = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    p_we = 1'b1; p_a3 = 5'd5; p_wd = 32'h1;
    #2;
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL reset_grf_we: got %0b want 0", grf_we); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_m_ready: got %0b want 0", m_ready); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL reset_pend: got %0h want 0", pend_mask); end
    checks++; if (starve !== 1'b0) begin errors++; $display("FAIL reset_starve: got %0b want 0", starve); end
    step();
    step();
    reset = 1'b1;
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL release_m_ready: got %0b want 1", m_ready); end
    checks++; if (grf_we !== 1'b1) begin errors++; $display("FAIL release_grf_we: got %0b want 1", grf_we); end
    step();
  endtask

  task automatic test_passthrough();
    idle_inputs();
    p_we = 1'b1; p_a3 = 5'd5; p_wd = 32'h1234; p_pc = 32'h400;
    #1;
    checks++; if ({grf_we, grf_a3, grf_wd, grf_pc} !== {1'b1, 5'd5, 32'h1234, 32'h400}) begin
      errors++; $display("FAIL pass_port: got we=%0b a3=%0d wd=%0h pc=%0h want 1 5 1234 400", grf_we, grf_a3, grf_wd, grf_pc);
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL pass_count: got %0d want 0", fifo_count); end
    p_a3 = 5'd0;
    #1;
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL pass_r0: got %0b want 0", grf_we); end
    step();
  endtask

  task automatic test_drain();
    idle_inputs();
    m_valid = 1'b1; m_a3 = 5'd8; m_wd = 32'hAA; m_pc = 32'h100;
    step();
    m_valid = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h100) begin errors++; $display("FAIL drain_pend: got %0h want 100", pend_mask); end
    checks++; if ({grf_we, grf_a3, grf_wd, grf_pc} !== {1'b1, 5'd8, 32'hAA, 32'h100}) begin
      errors++; $display("FAIL drain_port: got we=%0b a3=%0d wd=%0h pc=%0h want 1 8 aa 100", grf_we, grf_a3, grf_wd, grf_pc);
    end
    step();
    checks++; if (fifo_count !== 3'd0 || pend_mask !== 32'h0) begin
      errors++; $display("FAIL drain_empty: got count=%0d pend=%0h want 0 0", fifo_count, pend_mask);
    end
    m_valid = 1'b1; m_a3 = 5'd0; m_wd = 32'h55;
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL r0_push_ready: got %0b want 1", m_ready); end
    step();
    m_valid = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL r0_push_discard: got %0d want 0", fifo_count); end
  endtask

  task automatic test_kill();
    idle_inputs();
    p_we = 1'b1; p_a3 = 5'd3; p_wd = 32'h3;
    m_valid = 1'b1; m_a3 = 5'd9; m_wd = 32'h1111;
    step();
    m_valid = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h200) begin errors++; $display("FAIL kill_pend_before: got %0h want 200", pend_mask); end
    p_a3 = 5'd9; p_wd = 32'h9999;
    #1;
    checks++; if (grf_we !== 1'b1 || grf_wd !== 32'h9999) begin
      errors++; $display("FAIL kill_wstage: got we=%0b wd=%0h want 1 9999", grf_we, grf_wd);
    end
    step();
    p_we = 1'b0;
    #1;
    checks++; if (pend_mask !== 32'h0 || fifo_count !== 3'd1) begin
      errors++; $display("FAIL kill_pend_after: got pend=%0h count=%0d want 0 1", pend_mask, fifo_count);
    end
    checks++; if (grf_we !== 1'b0) begin errors++; $display("FAIL kill_dead_pop: got %0b want 0", grf_we); end
    step();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL kill_drained: got %0d want 0", fifo_count); end
    checks++; if (r9_last !== 32'h9999 || r9_writes !== 1) begin
      errors++; $display("FAIL kill_final: got r9=%0h writes=%0d want 9999 1", r9_last, r9_writes);
    end
    // Same-cycle push to the register the W stage is writing enters already dead.
    p_we = 1'b1; p_a3 = 5'd7; p_wd = 32'h7;
    m_valid = 1'b1; m_a3 = 5'd7; m_wd = 32'h77;
    step();
    idle_inputs();
    #1;
    checks++; if (fifo_count !== 3'd1 || pend_mask !== 32'h0 || grf_we !== 1'b0) begin
      errors++; $display("FAIL same_cycle_kill: got count=%0d pend=%0h we=%0b want 1 0 0", fifo_count, pend_mask, grf_we);
    end
    step();
  endtask

  task automatic test_full();
    idle_inputs();
    p_we = 1'b1; p_a3 = 5'd1; p_wd = 32'h1;
    for (int i = 0; i < 4; i++) begin
      m_valid = 1'b1; m_a3 = 5'(10 + i); m_wd = 32'(16'hA0 + i);
      step();
    end
    checks++; if (fifo_count !== 3'd4 || m_ready !== 1'b0) begin
      errors++; $display("FAIL full_state: got count=%0d ready=%0b want 4 0", fifo_count, m_ready);
    end
    checks++; if (pend_mask !== 32'h3C00) begin errors++; $display("FAIL full_pend: got %0h want 3c00", pend_mask); end
    m_a3 = 5'd14;
    step();
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_reject: got %0d want 4", fifo_count); end
    p_we = 1'b0;
    #1;
    checks++; if (m_ready !== 1'b0 || grf_a3 !== 5'd10 || grf_we !== 1'b1) begin
      errors++; $display("FAIL full_gap: got ready=%0b a3=%0d we=%0b want 0 10 1", m_ready, grf_a3, grf_we);
    end
    step();
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_no_push: got %0d want 3", fifo_count); end
    m_a3 = 5'd15;
    #1;
    checks++; if (m_ready !== 1'b1 || grf_a3 !== 5'd11) begin
      errors++; $display("FAIL full_gap2: got ready=%0b a3=%0d want 1 11", m_ready, grf_a3);
    end
    step();
    m_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_push_pop: got %0d want 3", fifo_count); end
    for (int i = 0; i < 3; i++) begin
      logic [4:0] exp_a3;
      exp_a3 = (i == 2) ? 5'd15 : 5'(12 + i);
      #1;
      checks++; if (grf_we !== 1'b1 || grf_a3 !== exp_a3) begin
        errors++; $display("FAIL wrap_order%0d: got we=%0b a3=%0d want 1 %0d", i, grf_we, grf_a3, exp_a3);
      end
      step();
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL wrap_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_starve();
    idle_inputs();
    p_we = 1'b1; p_a3 = 5'd2;
    m_valid = 1'b1; m_a3 = 5'd20; m_wd = 32'h2020;
    step();
    m_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      p_a3 = 5'(i + 1);
      step();
      if (i == 6) begin
        checks++; if (starve !== 1'b0) begin errors++; $display("FAIL starve_early: got %0b want 0", starve); end
      end
      if (i >= 7) begin
        checks++; if (starve !== 1'b1) begin errors++; $display("FAIL starve_set%0d: got %0b want 1", i, starve); end
      end
    end
    p_we = 1'b0;
    #1;
    checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd20 || grf_wd !== 32'h2020) begin
      errors++; $display("FAIL starve_drain: got we=%0b a3=%0d wd=%0h want 1 20 2020", grf_we, grf_a3, grf_wd);
    end
    step();
    checks++; if (starve !== 1'b0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL starve_clear: got starve=%0b count=%0d want 0 0", starve, fifo_count);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    p_we = 1'b1; p_a3 = 5'd1;
    for (int i = 0; i < 3; i++) begin
      m_valid = 1'b1; m_a3 = 5'(21 + i); m_wd = 32'(i);
      step();
    end
    m_valid = 1'b0;
    p_we = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd3 || pend_mask !== 32'h00E0_0000 || grf_a3 !== 5'd21) begin
      errors++; $display("FAIL pre_reset: got count=%0d pend=%0h a3=%0d want 3 e00000 21", fifo_count, pend_mask, grf_a3);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (grf_we !== 1'b0 || m_ready !== 1'b0 || fifo_count !== 3'd0 || pend_mask !== 32'h0) begin
      errors++; $display("FAIL async_reset: got we=%0b ready=%0b count=%0d pend=%0h want 0 0 0 0", grf_we, m_ready, fifo_count, pend_mask);
    end
    step();
    step();
    reset = 1'b1;
    #1;
    checks++; if (m_ready !== 1'b1 || grf_we !== 1'b0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL post_reset: got ready=%0b we=%0b count=%0d want 1 0 0", m_ready, grf_we, fifo_count);
    end
    step();
    step();
    checks++; if (stale_writes !== 0) begin errors++; $display("FAIL stale_write: got %0d want 0", stale_writes); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_drain();
    test_kill();
    test_full();
    test_starve();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Arbiter and sequencer for the single GRF write port. It shares that port between the pipeline W stage and a late-writeback source, such as the multi-cycle multiply/divide unit. Late results wait in a small in-order queue that drains only into cycles the W stage leaves unused. The block also publishes a pending-write mask for the hazard unit and kills queued writes that a younger W-stage write has made stale.

## Interface
Parameters:
- DEPTH, 4, late-write queue entries; power of two, ≥2.
- STARVE_MAX, 8, consecutive denied cycles before `starve` asserts; ≥1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- p_we  in  1  W-stage write request; never back-pressured.
- p_a3  in  5  W-stage destination register.
- p_wd  in  32  W-stage write data.
- p_pc  in  32  W-stage PC, passed through for the write log.
- m_valid  in  1  late source offers a write.
- m_ready  out  1  queue accepts a write; equals !full.
- m_a3  in  5  late destination register.
- m_wd  in  32  late write data.
- m_pc  in  32  late PC.
- grf_we  out  1  write enable to the GRF.
- grf_a3  out  5  write address to the GRF.
- grf_wd  out  32  write data to the GRF.
- grf_pc  out  32  PC to the GRF write log.
- pend_mask  out  32  bit r=1 while any live queued entry targets register r; bit 0 is always 0.
- fifo_count  out  $clog2(DEPTH)+1  occupancy, counting killed entries.
- starve  out  1  queue head denied for STARVE_MAX consecutive cycles.

## Operation
- Effective W-stage write: pw = p_we && p_a3!=0.
- Effective push: push = m_valid && m_ready && m_a3!=0. A handshake with m_a3==0 is accepted and discarded; nothing is enqueued.
- Queue entry: {live, a3, wd, pc}. Entries push at the tail and pop at the head on the clock edge.
- Port select, combinational:
  - If pw: grf_* = p_*, grf_we=1.
  - Else if the head is live: grf_* = head fields, grf_we=1, head pops.
  - Otherwise grf_we=0, and grf_a3/wd/pc show the p_* values.
- Dead head: pops in any cycle, in parallel with a W-stage write. It never drives grf_we.
- Kill rule: when pw, every queued entry whose a3 equals p_a3 has live cleared at the edge. A same-cycle push with m_a3==p_a3 enqueues with live=0, because the W-stage write is treated as younger.
- pend_mask is the OR-decode of a3 over live entries. It is combinational from registered state.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each cycle where the head is live and pw=1.
  - Clears when the head pops or the queue is empty.
  - starve = (counter == STARVE_MAX).
  - The block never stalls the W stage itself. The stall controller answers starve by inserting W bubbles.
- Full, empty and wrap:
  - Pointers wrap modulo DEPTH.
  - m_ready is computed from the current count, so a full queue rejects a push even in a cycle that pops.
  - Push and pop in the same cycle keeps the count unchanged.

## Timing
- Queue latency: an entry pushed at edge N reaches the GRF at the earliest in cycle N+1, with its write at edge N+1. There is no push-to-port bypass.
- W-stage path: zero added latency. grf_* equals p_* in the same cycle.
- Reset: while reset=0, all outputs are forced as follows:
  - grf_we=0.
  - m_ready=0.
  - pend_mask=0.
  - fifo_count=0.
  - starve=0.
  - Pointers, live bits and the starvation counter clear.
- Reset mid-drain discards all queued writes; no partial write is issued.
- After release, m_ready=1 from the first cycle.

## Test plan
- Idle pass-through: p_we=1, p_a3=5, p_wd=0x1234, queue empty → grf_we=1, grf_a3=5, grf_wd=0x1234 in the same cycle; fifo_count=0.
- Drain into a gap: push m_a3=8, m_wd=0xAA at edge 0, p_we=0 → pend_mask=0x100 in cycle 1; cycle 1 shows grf_we=1, grf_a3=8, grf_wd=0xAA; cycle 2 shows fifo_count=0, pend_mask=0.
- Kill: queue holds live r9; cycle with p_we=1, p_a3=9 → pend_mask bit 9 clears after the edge; the r9 entry later pops with grf_we=0; the final GRF value is the W-stage data.
- Full: push 4 entries with p_we held at 1 → fifo_count=4, m_ready=0; a fifth m_valid is not accepted; one gap cycle lets the count drop to 3, and the count stays 3 when a push lands that same cycle.
- Starvation: one queued live entry, p_we=1 to nonzero registers for 8 cycles → starve=1 from cycle 8 onward; the first cycle with p_we=0 drains it, and starve=0 in the next cycle.
- Async reset: assert reset=0 mid-clock with 3 entries queued → grf_we, m_ready and fifo_count are 0 without waiting for a clock edge; after release the queue is empty and no stale write is issued.
